reg_file_sb: RTL

Parametrised multi-read-port register file for the MIPS pipeline, with a per-register busy scoreboard and a sequential clear engine. Decode reads operands and producer status through NUM_RD read ports. Writeback updates registers and retires busy bits through one write port. Register 0 is hardwired to zero. Writes bypass to same-cycle reads, so the pipeline needs no separate WB→ID forwarding path.

---
 rtl/reg_file_sb_pkg.sv | 9 +
 rtl/reg_file_sb_if.sv | 28 ++
 rtl/reg_file_sb_scoreboard.sv | 35 +++
 rtl/reg_file_sb.sv | 70 +++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// regfile_pkg: FSM state type, default sizes and port-slice helper shared by reg_file_sb.
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_NUM_REGS = 32;
  function automatic int slice_lo(int p, int w);
    return p * w;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read/write/issue/clear bus of the scoreboarded register file.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NUM_REGS);
  logic clr_req;
  logic ready;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  modport master (
    output clr_req, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input ready, rd_data, rd_busy
  );
  modport slave (
    input clr_req, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output ready, rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits with issue set, writeback clear and flush.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_RD = 2,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic set_en,
  input  logic [AW-1:0] set_addr,
  input  logic clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [NUM_RD*AW-1:0] lk_addr,
  output logic [NUM_RD-1:0] lk_busy
);
  logic [NUM_REGS-1:0] busy, busy_n;
  // set is applied after clear so a same-cycle new producer wins
  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_addr] = 1'b0;
    if (set_en) busy_n[set_addr] = 1'b1;
    if (flush) busy_n = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= busy_n;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_lk
    logic [AW-1:0] a;
    assign a = lk_addr[slice_lo(p, AW) +: AW];
    assign lk_busy[p] = !(clr_en && clr_addr == a) && busy[a];
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with write bypass, busy scoreboard
// and a sequential clear sweep that runs after reset or on request.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_RD = 2
) (
  input logic clk,
  input logic rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  state_t state, state_n;
  logic [AW-1:0] clr_ptr, clr_ptr_n;
  logic run, arr_we, wr_we;
  logic [AW-1:0] arr_wa;
  logic [DATA_W-1:0] arr_wd;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_RD-1:0] lk_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_n;
      clr_ptr <= clr_ptr_n;
    end
  always_comb begin
    state_n = state;
    clr_ptr_n = '0;
    if (bus.clr_req) state_n = CLEAR;
    else if (state == CLEAR) begin
      clr_ptr_n = clr_ptr + AW'(1);
      if (clr_ptr == AW'(NUM_REGS - 1)) state_n = RUN;
    end
  end
  // the array port is shared between the sweep and writeback
  always_comb begin
    run = state == RUN;
    wr_we = run && bus.wr_en && bus.wr_addr != '0;
    arr_we = run ? wr_we : 1'b1;
    arr_wa = run ? bus.wr_addr : clr_ptr;
    arr_wd = run ? bus.wr_data : '0;
  end
  assign bus.ready = run;
  always_ff @(posedge clk)
    if (arr_we) mem[arr_wa] <= arr_wd;
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .flush(bus.clr_req),
    .set_en(run && bus.iss_en && bus.iss_addr != '0),
    .set_addr(bus.iss_addr),
    .clr_en(wr_we),
    .clr_addr(bus.wr_addr),
    .lk_addr(bus.rd_addr),
    .lk_busy(lk_busy)
  );
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = bus.rd_addr[slice_lo(p, AW) +: AW];
    assign hit = run && a != '0;
    assign bus.rd_data[slice_lo(p, DATA_W) +: DATA_W] =
      !hit ? '0 : wr_we && bus.wr_addr == a ? bus.wr_data : mem[a];
    assign bus.rd_busy[p] = hit && lk_busy[p];
  end
endmodule
